// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter: round-robin sharing of one FPU among NREQ requesters with timeout watchdog
module fpu_req_arbiter #(
  parameter int NREQ = 4,
  parameter int TIMEOUT = 64,
  parameter logic [31:0] ERR_VAL = 32'h7FC0_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_cmd,
  input  logic [32*NREQ-1:0]   req_din1,
  input  logic [32*NREQ-1:0]   req_din2,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_result,
  output logic                 rsp_err,
  output logic [3:0]           fpu_cmd,
  output logic [31:0]          fpu_din1,
  output logic [31:0]          fpu_din2,
  output logic                 fpu_dval,
  input  logic [31:0]          fpu_result,
  input  logic                 fpu_rdy,
  output logic                 busy
);
  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, nxt;
  logic [IW-1:0] rr_ptr, g, win, idx;
  logic [TW-1:0] tmr;
  logic found, tmo;
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(rr_ptr) + k) % NREQ);
      if (req_valid[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  assign tmo = tmr == TW'(TIMEOUT - 1);
  always_comb begin
    nxt = state == IDLE  ? (found ? ISSUE : IDLE) :
          state == ISSUE ? WAIT :
          state == WAIT  ? ((fpu_rdy || tmo) ? RESP : WAIT) :
                           (rsp_ready[g] ? IDLE : RESP);
  end
  assign req_ready = (state == IDLE && found) ? NREQ'(1) << win : '0;
  assign rsp_valid = state == RESP ? NREQ'(1) << g : '0;
  assign fpu_dval = state == ISSUE;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= IW'(NREQ - 1);
      g <= '0;
      fpu_cmd <= '0;
      fpu_din1 <= '0;
      fpu_din2 <= '0;
      tmr <= '0;
      rsp_result <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && found) begin
        g <= win;
        rr_ptr <= win;
        fpu_cmd <= req_cmd[{win, 2'b00} +: 4];
        fpu_din1 <= req_din1[{win, 5'b00000} +: 32];
        fpu_din2 <= req_din2[{win, 5'b00000} +: 32];
      end
      tmr <= state == WAIT ? tmr + 1'b1 : '0;
      if (state == WAIT && fpu_rdy) begin
        rsp_result <= fpu_result;
        rsp_err <= 1'b0;
      end else if (state == WAIT && tmo) begin
        rsp_result <= ERR_VAL;
        rsp_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fpu_req_arbiter.sv
// tb_fpu_req_arbiter: directed self-checking bench for fpu_req_arbiter
module tb_fpu_req_arbiter;
  localparam int NREQ = 4;
  localparam int TIMEOUT = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [3:0] rsp_ready = '0;
  logic [15:0] req_cmd = '0;
  logic [127:0] req_din1 = '0;
  logic [127:0] req_din2 = '0;
  logic [31:0] fpu_result = '0;
  logic fpu_rdy = 1'b0;
  logic [3:0] req_ready, rsp_valid, fpu_cmd;
  logic [31:0] rsp_result, fpu_din1, fpu_din2;
  logic rsp_err, fpu_dval, busy;
  int checks = 0;
  int errors = 0;
  int dval_cnt = 0;
  fpu_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .ERR_VAL(32'h7FC0_0000)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_din1(req_din1), .req_din2(req_din2), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .fpu_cmd(fpu_cmd), .fpu_din1(fpu_din1),
    .fpu_din2(fpu_din2), .fpu_dval(fpu_dval), .fpu_result(fpu_result), .fpu_rdy(fpu_rdy),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (fpu_dval) dval_cnt <= dval_cnt + 1;
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, fpu_dval, busy} !== 11'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b exp 0", {req_ready, rsp_valid, rsp_err, fpu_dval, busy});
    end
    checks++;
    if ({rsp_result, fpu_cmd, fpu_din1, fpu_din2} !== 100'b0) begin
      errors++;
      $display("FAIL reset_data: got %h exp 0", {rsp_result, fpu_cmd, fpu_din1, fpu_din2});
    end
    rst = 1'b0;
  endtask
  task automatic test_single;
    int d0;
    d0 = dval_cnt;
    @(negedge clk);
    req_valid = 4'b0100;
    req_cmd[11:8] = 4'd0;
    req_din1[95:64] = 32'h3F80_0000;
    req_din2[95:64] = 32'h4000_0000;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b exp 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if ({fpu_dval, fpu_cmd, fpu_din1, fpu_din2} !== {1'b1, 4'd0, 32'h3F80_0000, 32'h4000_0000}) begin
      errors++;
      $display("FAIL single_issue: got dval=%b cmd=%h d1=%h d2=%h exp 1 0 3f800000 40000000", fpu_dval, fpu_cmd, fpu_din1, fpu_din2);
    end
    @(negedge clk);
    checks++;
    if (fpu_dval !== 1'b0 || fpu_din1 !== 32'h3F80_0000) begin
      errors++;
      $display("FAIL single_wait: got dval=%b d1=%h exp 0 3f800000", fpu_dval, fpu_din1);
    end
    @(negedge clk);
    @(negedge clk);
    fpu_rdy = 1'b1;
    fpu_result = 32'h4040_0000;
    @(negedge clk);
    fpu_rdy = 1'b0;
    checks++;
    if ({rsp_valid, rsp_result, rsp_err} !== {4'b0100, 32'h4040_0000, 1'b0}) begin
      errors++;
      $display("FAIL single_resp: got v=%b r=%h e=%b exp 0100 40400000 0", rsp_valid, rsp_result, rsp_err);
    end
    checks++;
    if (dval_cnt - d0 !== 1) begin errors++; $display("FAIL single_dval_count: got %0d exp 1", dval_cnt - d0); end
    rsp_ready = 4'b0100;
    @(negedge clk);
    rsp_ready = '0;
    checks++;
    if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_release: got v=%b busy=%b exp 0000 0", rsp_valid, busy);
    end
  endtask
  task automatic test_round_robin;
    int exp_g[5] = '{0, 1, 2, 3, 0};
    int d0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_cmd[4*i +: 4] = 4'(i + 1);
      req_din1[32*i +: 32] = 32'h1000_0000 + 32'(i);
    end
    req_valid = 4'b1111;
    d0 = dval_cnt;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (req_ready !== 4'(1 << exp_g[k])) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b exp %b", k, req_ready, 4'(1 << exp_g[k]));
      end
      @(negedge clk);
      checks++;
      if (fpu_dval !== 1'b1 || fpu_din1 !== 32'h1000_0000 + 32'(exp_g[k]) || fpu_cmd !== 4'(exp_g[k] + 1)) begin
        errors++;
        $display("FAIL rr_issue%0d: got dval=%b d1=%h cmd=%h exp req %0d", k, fpu_dval, fpu_din1, fpu_cmd, exp_g[k]);
      end
      @(negedge clk);
      fpu_rdy = 1'b1;
      fpu_result = 32'hA000_0000 + 32'(k);
      @(negedge clk);
      fpu_rdy = 1'b0;
      checks++;
      if (rsp_valid !== 4'(1 << exp_g[k]) || rsp_result !== 32'hA000_0000 + 32'(k) || req_ready !== 4'b0) begin
        errors++;
        $display("FAIL rr_resp%0d: got v=%b r=%h rdy=%b exp %b %h 0000", k, rsp_valid, rsp_result, req_ready, 4'(1 << exp_g[k]), 32'hA000_0000 + 32'(k));
      end
      rsp_ready = 4'b1111;
      @(negedge clk);
      rsp_ready = '0;
    end
    req_valid = '0;
    checks++;
    if (dval_cnt - d0 !== 5) begin errors++; $display("FAIL rr_dval_count: got %0d exp 5", dval_cnt - d0); end
  endtask
  task automatic test_timeout;
    int n;
    bit done;
    n = 0;
    done = 0;
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL to_ready: got %b exp 1000", req_ready); end
    @(negedge clk);
    req_valid = '0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0) done = 1;
      else n++;
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL to_bound: got no response exp response within 100 cycles"); end
    checks++;
    if (n !== TIMEOUT) begin errors++; $display("FAIL to_cycles: got %0d exp %0d", n, TIMEOUT); end
    checks++;
    if ({rsp_valid, rsp_result, rsp_err} !== {4'b1000, 32'h7FC0_0000, 1'b1}) begin
      errors++;
      $display("FAIL to_resp: got v=%b r=%h e=%b exp 1000 7fc00000 1", rsp_valid, rsp_result, rsp_err);
    end
    rsp_ready = 4'b1000;
    @(negedge clk);
    rsp_ready = '0;
    fpu_rdy = 1'b1;
    fpu_result = 32'h1111_1111;
    @(negedge clk);
    fpu_rdy = 1'b0;
    checks++;
    if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_late_rdy: got v=%b busy=%b exp 0000 0", rsp_valid, busy);
    end
  endtask
  task automatic test_backpressure;
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_ready: got %b exp 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b1101;
    @(negedge clk);
    fpu_rdy = 1'b1;
    fpu_result = 32'hC0A0_0000;
    @(negedge clk);
    fpu_rdy = 1'b0;
    rsp_ready = 4'b1101;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if ({rsp_valid, rsp_result, req_ready} !== {4'b0010, 32'hC0A0_0000, 4'b0000}) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b r=%h rdy=%b exp 0010 c0a00000 0000", c, rsp_valid, rsp_result, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 4'b0010;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    checks++;
    if ({busy, rsp_valid, req_ready} !== {1'b0, 4'b0000, 4'b0100}) begin
      errors++;
      $display("FAIL bp_release: got busy=%b v=%b rdy=%b exp 0 0000 0100", busy, rsp_valid, req_ready);
    end
    req_valid = '0;
  endtask
  task automatic test_reset_mid_wait;
    @(negedge clk);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, rsp_valid, req_ready, fpu_dval, rsp_err} !== 11'b0 || {rsp_result, fpu_cmd, fpu_din1, fpu_din2} !== 100'b0) begin
      errors++;
      $display("FAIL rmw_outputs: got busy=%b v=%b dval=%b d1=%h r=%h exp all 0", busy, rsp_valid, fpu_dval, fpu_din1, rsp_result);
    end
    fpu_rdy = 1'b1;
    fpu_result = 32'h1234_5678;
    @(negedge clk);
    fpu_rdy = 1'b0;
    checks++;
    if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmw_late_rdy: got v=%b busy=%b exp 0000 0", rsp_valid, busy);
    end
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmw_priority: got %b exp 0001", req_ready); end
    req_valid = '0;
  endtask
  task automatic test_collision;
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL col_ready: got %b exp 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(negedge clk);
      if (c == TIMEOUT) begin
        checks++;
        if (rsp_valid !== 4'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL col_waiting: got v=%b busy=%b exp 0000 1", rsp_valid, busy);
        end
        fpu_rdy = 1'b1;
        fpu_result = 32'h4120_0000;
      end
    end
    @(negedge clk);
    fpu_rdy = 1'b0;
    checks++;
    if ({rsp_valid, rsp_result, rsp_err} !== {4'b0010, 32'h4120_0000, 1'b0}) begin
      errors++;
      $display("FAIL col_resp: got v=%b r=%h e=%b exp 0010 41200000 0", rsp_valid, rsp_result, rsp_err);
    end
    rsp_ready = 4'b0010;
    @(negedge clk);
    rsp_ready = '0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL col_release: got busy=%b exp 0", busy); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_timeout;
    test_backpressure;
    test_reset_mid_wait;
    test_collision;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
